// File: rtl/dcache_controller_if.sv
// Bus bundle between the data-cache controller, its 2-way SRAM array and the
// backing line memory. The master modport is the controller's view.
interface dcache_controller_if;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;

    logic         sram_enable_o;
    logic         sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_hit_i;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;

    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    modport master (
        input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_stall_o,
        output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
        input  sram_hit_i, sram_tag_i, sram_data_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport slave (
        output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_stall_o,
        input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
        output sram_hit_i, sram_tag_i, sram_data_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );
endinterface

// File: rtl/dcache_controller.sv
// Write-back data-cache controller: single-cycle hits, and on a miss an optional
// dirty-victim write-back, a line refill, an SRAM fill and a replay of the access.
module dcache_controller (
    input  logic               clk_i,
    input  logic               rst_n_i,
    dcache_controller_if.master bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [22:0]   victim_tag_r;
    logic [255:0]  victim_data_r;
    logic [255:0]  refill_r;
    logic          pulse_r;

    logic [22:0]   tag_s;
    logic [3:0]    index_s;
    logic [2:0]    word_s;
    logic          miss_s;
    logic          unused_s;

    assign tag_s    = bus.cpu_addr_i[31:9];
    assign index_s  = bus.cpu_addr_i[8:5];
    assign word_s   = bus.cpu_addr_i[4:2];
    assign miss_s   = (state_r == IDLE) && bus.cpu_req_i && !bus.sram_hit_i;
    assign unused_s = ^bus.cpu_addr_i[1:0];

    function automatic logic [255:0] merge_word(input logic [255:0] line,
                                                input logic [2:0]   word,
                                                input logic [31:0]  data);
        logic [255:0] merged;
        merged = line;
        merged[{word, 5'b00000} +: 32] = data;
        return merged;
    endfunction

    // State register, victim/refill capture and the memory-request pulse flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r       <= IDLE;
            victim_tag_r  <= 23'd0;
            victim_data_r <= 256'd0;
            refill_r      <= 256'd0;
            pulse_r       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            // A fresh memory request is issued only on entry to a memory state,
            // including the WRITEBACK->REFILL hop after a same-cycle ack.
            pulse_r <= (next_state_s != state_r) &&
                       ((next_state_s == WRITEBACK) || (next_state_s == REFILL));
            if (miss_s) begin
                victim_tag_r  <= bus.sram_tag_i[22:0];
                victim_data_r <= bus.sram_data_i;
            end else begin
                victim_tag_r  <= victim_tag_r;
                victim_data_r <= victim_data_r;
            end
            if ((state_r == REFILL) && bus.mem_ack_i) begin
                refill_r <= bus.mem_data_i;
            end else begin
                refill_r <= refill_r;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
                        next_state_s = WRITEBACK;
                    end else begin
                        next_state_s = REFILL;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack_i) begin
                    next_state_s = REFILL;
                end else begin
                    next_state_s = WRITEBACK;
                end
            end
            REFILL: begin
                if (bus.mem_ack_i) begin
                    next_state_s = REFILL_DONE;
                end else begin
                    next_state_s = REFILL;
                end
            end
            REFILL_DONE: next_state_s = IDLE;
            default:     next_state_s = IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        bus.cpu_data_o    = 32'd0;
        bus.cpu_stall_o   = 1'b0;
        bus.sram_enable_o = 1'b0;
        bus.sram_write_o  = 1'b0;
        bus.sram_addr_o   = 4'd0;
        bus.sram_tag_o    = 25'd0;
        bus.sram_data_o   = 256'd0;
        bus.mem_enable_o  = 1'b0;
        bus.mem_write_o   = 1'b0;
        bus.mem_addr_o    = 32'd0;
        bus.mem_data_o    = 256'd0;
        if (rst_n_i) begin
            bus.sram_addr_o = index_s;
            bus.sram_tag_o  = {2'b00, tag_s};
            case (state_r)
                IDLE: begin
                    if (bus.cpu_req_i) begin
                        if (bus.sram_hit_i) begin
                            bus.sram_enable_o = 1'b1;
                            if (bus.cpu_write_i) begin
                                bus.sram_write_o = 1'b1;
                                bus.sram_tag_o   = {2'b11, tag_s};
                                bus.sram_data_o  = merge_word(bus.sram_data_i, word_s,
                                                              bus.cpu_data_i);
                            end else begin
                                bus.cpu_data_o = bus.sram_data_i[{word_s, 5'b00000} +: 32];
                            end
                        end else begin
                            bus.cpu_stall_o = 1'b1;
                        end
                    end else begin
                        bus.cpu_stall_o = 1'b0;
                    end
                end
                WRITEBACK: begin
                    bus.cpu_stall_o  = 1'b1;
                    bus.mem_enable_o = pulse_r;
                    bus.mem_write_o  = 1'b1;
                    bus.mem_addr_o   = {victim_tag_r, index_s, 5'b00000};
                    bus.mem_data_o   = victim_data_r;
                end
                REFILL: begin
                    bus.cpu_stall_o  = 1'b1;
                    bus.mem_enable_o = pulse_r;
                    bus.mem_addr_o   = {tag_s, index_s, 5'b00000};
                end
                REFILL_DONE: begin
                    // The line lands clean; a pending store dirties it on replay.
                    bus.cpu_stall_o   = 1'b1;
                    bus.sram_enable_o = 1'b1;
                    bus.sram_write_o  = 1'b1;
                    bus.sram_tag_o    = {2'b10, tag_s};
                    bus.sram_data_o   = refill_r;
                end
                default: begin
                    bus.cpu_stall_o = 1'b1;
                end
            endcase
        end else begin
            bus.cpu_stall_o = 1'b0;
        end
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Cache-side controller that drives the 2-way data-cache SRAM array and issues line-sized requests to the backing data memory.
- Accepts word accesses from the CPU MEM stage and services hits in the request cycle.
- On a miss it stalls the CPU, writes back a dirty victim, refills the line, and then replays the access.

Parameters:
- none; geometry is fixed: 32-bit byte address, 32-byte line, 16 sets, 23-bit tag, 25-bit SRAM tag word ([24] valid, [23] dirty, [22:0] tag)

Ports:
- clk_i in 1 clock
- rst_n_i in 1 asynchronous active-low reset
- cpu_req_i in 1 CPU access request, held until cpu_stall_o low
- cpu_write_i in 1 1=store, 0=load
- cpu_addr_i in 32 byte address; [31:9] tag, [8:5] index, [4:2] word, [1:0] ignored
- cpu_data_i in 32 store data
- cpu_data_o out 32 load data
- cpu_stall_o out 1 CPU must hold the request
- sram_enable_o out 1 SRAM enable
- sram_write_o out 1 SRAM write strobe
- sram_addr_o out 4 set index
- sram_tag_o out 25 tag word to SRAM
- sram_data_o out 256 line to SRAM
- sram_hit_i in 1 tag match in either way
- sram_tag_i in 25 tag word of hit or LRU victim way
- sram_data_i in 256 line of hit or LRU victim way
- mem_enable_o out 1 memory request pulse
- mem_write_o out 1 1=line write, 0=line read
- mem_addr_o out 32 line-aligned address ([4:0]=0)
- mem_data_o out 256 write-back line
- mem_ack_i in 1 one-cycle completion pulse
- mem_data_i in 256 refill line, valid while mem_ack_i=1

Behaviour:
- Reset (rst_n_i=0, async): state=IDLE, refill buffer cleared, all outputs 0 (including cpu_stall_o) while reset is asserted.
- sram_addr_o = cpu_addr_i[8:5] always.
- sram_tag_o[22:0] = cpu_addr_i[31:9] except during write-back-address formation.
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
- IDLE with cpu_req_i=0:
  - sram_enable_o=0, cpu_stall_o=0.
- IDLE with cpu_req_i=1 and sram_hit_i=1 (hit):
  - cpu_stall_o=0 (combinational, same cycle), sram_enable_o=1.
  - Load: cpu_data_o = sram_data_i[32*word +: 32], sram_write_o=0; the SRAM updates LRU.
  - Store: sram_write_o=1, sram_data_o = sram_data_i with word slice replaced by cpu_data_i, sram_tag_o = {1,1,tag}.
  - Zero added latency.
- IDLE with cpu_req_i=1 and sram_hit_i=0 (miss):
  - cpu_stall_o=1 the same cycle.
  - Latch the victim {sram_tag_i, sram_data_i}.
  - Next state: WRITEBACK if victim valid and dirty ([24]&[23]), else REFILL.
- WRITEBACK:
  - mem_enable_o=1 in the first cycle of the state only; mem_write_o=1.
  - mem_addr_o = {victim_tag[22:0], index, 5'b0}, mem_data_o = latched victim line; both held stable until ack.
  - On mem_ack_i=1, go to REFILL.
- REFILL:
  - mem_enable_o pulses in the first cycle; mem_write_o=0.
  - mem_addr_o = {cpu_addr_i[31:9], index, 5'b0}.
  - On mem_ack_i=1, latch mem_data_i into the refill buffer and go to REFILL_DONE.
- REFILL_DONE (one cycle):
  - sram_enable_o=1, sram_write_o=1, sram_tag_o = {1,0,tag}, sram_data_o = refill buffer.
  - Next state IDLE; the access is re-evaluated there and hits.
  - A store is merged at that replay via the write-hit path.
- cpu_stall_o=1 in every non-IDLE state.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- An ack in the pulse cycle itself is legal and honoured.
- Requests are not accepted while stalled; cpu inputs must be stable from the miss until stall drops.
- Reset mid-miss: abort immediately to IDLE; no SRAM write. The memory transaction is abandoned and a late ack is ignored.
- Miss total latency = 1 (detect) + write-back wait (if dirty) + refill wait + 1 (REFILL_DONE), then the hit cycle.

Test Plan:
- Reset: rst_n_i=0 mid-REFILL -> state IDLE, cpu_stall_o=0, mem_enable_o=0, no SRAM write; a later mem_ack_i is ignored.
- Load hit: sram_hit_i=1, addr 0x0000_0048, sram_data_i word2=0xDEADBEEF -> cpu_data_o=0xDEADBEEF, cpu_stall_o=0, sram_write_o=0, same cycle.
- Store hit: addr 0x0000_0044, data 0x12345678 -> sram_write_o=1, sram_tag_o[24:23]=2'b11, word1 of sram_data_o=0x12345678, other words unchanged.
- Clean miss: load 0x0000_1220, victim tag valid/clean -> one mem_enable_o pulse with mem_write_o=0, mem_addr_o=0x0000_1220. Ack after 10 cycles -> REFILL_DONE writes tag {1,0,0x9}, then the hit returns data; stall lasts 12 cycles.
- Dirty miss: victim tag word {1,1,0x7F}, index 3 -> write-back mem_addr_o=0x0000_FE60 with the victim line, then a refill read. Exactly two mem_enable_o pulses in order write, read.
- Store miss: store to a clean-miss address -> refill, then the replayed store sets dirty and merges the word. A subsequent load of that address returns the stored value.
